// File: rtl/uart_alu_pkg.sv
// Shared constants and types for the UART arithmetic engine: opcodes, packet FSM states,
// and the default bit-rate prescaler.
package uart_alu_pkg;

    localparam logic [7:0]  OP_ECHO          = 8'hEC;
    localparam logic [7:0]  OP_ADD           = 8'h10;
    localparam logic [7:0]  OP_MUL           = 8'h11;
    localparam logic [15:0] DEFAULT_PRESCALE = 16'd35;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        RESULT
    } state_e;

endpackage

// File: rtl/uart_alu_phy.sv
// 8N1 UART transmitter and receiver with valid/ready byte interfaces.
// One bit lasts 8*PRESCALE clock cycles.
module uart_phy #(
    parameter logic [15:0] PRESCALE = 16'd35
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       tx_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_busy_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       rx_busy_o,
    output logic       rx_frame_err_o
);

    localparam logic [18:0] BIT_CYC  = 19'(8 * PRESCALE);
    localparam logic [18:0] HALF_CYC = 19'(4 * PRESCALE);

    logic        rx_meta_q, rx_sync_q, rx_arm_q, rx_busy_q;
    logic [18:0] rx_cnt_q;
    logic [3:0]  rx_bit_q;
    logic [7:0]  rx_shift_q, rx_data_q;
    logic        rx_valid_q, rx_ferr_q;

    // The receiver re-arms only after seeing the line high, so a low stop bit
    // cannot be mistaken for the next start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_arm_q   <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_ferr_q <= 1'b0;
            if (rx_valid_q && rx_ready_i) rx_valid_q <= 1'b0;
            if (!rx_busy_q) begin
                rx_arm_q <= rx_sync_q;
                if (rx_arm_q && !rx_sync_q) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= HALF_CYC - 19'd1;
                    rx_bit_q  <= '0;
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - 19'd1;
            end else begin
                rx_cnt_q <= BIT_CYC - 19'd1;
                if (rx_bit_q == 4'd0) begin
                    if (rx_sync_q) rx_busy_q <= 1'b0;
                    else           rx_bit_q  <= 4'd1;
                end else if (rx_bit_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                    rx_arm_q  <= 1'b0;
                    if (rx_sync_q) begin
                        rx_data_q  <= rx_shift_q;
                        rx_valid_q <= 1'b1;
                    end else begin
                        rx_ferr_q <= 1'b1;
                    end
                end else begin
                    rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_q   <= rx_bit_q + 4'd1;
                end
            end
        end
    end

    assign rx_data_o      = rx_data_q;
    assign rx_valid_o     = rx_valid_q;
    assign rx_busy_o      = rx_busy_q;
    assign rx_frame_err_o = rx_ferr_q;

    logic        tx_q, tx_busy_q, tx_done;
    logic [18:0] tx_cnt_q;
    logic [3:0]  tx_bit_q;
    logic [8:0]  tx_shift_q;

    // Accepting a new byte in the last stop-bit cycle keeps back-to-back frames gapless.
    assign tx_done    = tx_busy_q && (tx_cnt_q == '0) && (tx_bit_q == 4'd0);
    assign tx_ready_o = !tx_busy_q || tx_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
        end else if (tx_valid_i && tx_ready_o) begin
            tx_shift_q <= {1'b1, tx_data_i};
            tx_q       <= 1'b0;
            tx_bit_q   <= 4'd9;
            tx_cnt_q   <= BIT_CYC - 19'd1;
            tx_busy_q  <= 1'b1;
        end else if (tx_busy_q) begin
            if (tx_cnt_q != '0) begin
                tx_cnt_q <= tx_cnt_q - 19'd1;
            end else if (tx_bit_q == 4'd0) begin
                tx_busy_q <= 1'b0;
            end else begin
                tx_q       <= tx_shift_q[0];
                tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                tx_bit_q   <= tx_bit_q - 4'd1;
                tx_cnt_q   <= BIT_CYC - 19'd1;
            end
        end
    end

    assign tx_o      = tx_q;
    assign tx_busy_o = tx_busy_q;

endmodule

// File: rtl/uart_alu.sv
// Packet engine over UART: echo, 32-bit add and (with UART_ALU_MUL_EN) 32-bit multiply.
// Results leave through a 4-entry TX FIFO.
module uart_alu
    import uart_alu_pkg::*;
#(
    parameter logic [15:0] PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic tx_o
);

    logic [7:0] rx_data, tx_data;
    logic       rx_valid, rx_ready, tx_valid, tx_ready;
    logic       tx_busy, rx_busy, rx_ferr;

    uart_phy #(.PRESCALE(PRESCALE)) u_phy (
        .clk            (clk),
        .rst            (rst),
        .rx_i           (rx_i),
        .tx_o           (tx_o),
        .tx_data_i      (tx_data),
        .tx_valid_i     (tx_valid),
        .tx_ready_o     (tx_ready),
        .tx_busy_o      (tx_busy),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
        .rx_ready_i     (rx_ready),
        .rx_busy_o      (rx_busy),
        .rx_frame_err_o (rx_ferr)
    );

    // Framing errors are already dropped inside the PHY; the flags are informational only.
    logic unused_phy;
    assign unused_phy = &{1'b0, tx_busy, rx_busy, rx_ferr};

    function automatic logic op_supported(input logic [7:0] b);
`ifdef UART_ALU_MUL_EN
        return (b == OP_ECHO) || (b == OP_ADD) || (b == OP_MUL);
`else
        return (b == OP_ECHO) || (b == OP_ADD);
`endif
    endfunction

    logic [7:0] fifo_mem_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q;
    logic       fifo_full, pop, push_en;
    logic [7:0] push_data;

    assign fifo_full = (count_q == 3'd4);
    assign tx_valid  = (count_q != 3'd0);
    assign tx_data   = fifo_mem_q[rd_ptr_q];
    assign pop       = tx_valid && tx_ready;

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_en) fifo_mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + {2'b0, push_en} - {2'b0, pop};
        end
    end

    state_e      state_q;
    logic [7:0]  opcode_q, skid_q;
    logic [15:0] len_q, cnt_q;
    logic [31:0] word_q, acc_q, acc_upd;
    logic        word_done_q, have_word_q, skid_valid_q;
    logic [1:0]  res_idx_q;
    logic        byte_fire, result_push;

    assign rx_ready    = !skid_valid_q;
    assign byte_fire   = rx_valid && rx_ready;
    assign result_push = (state_q == RESULT) && !skid_valid_q && !word_done_q && !fifo_full;

`ifdef UART_ALU_MUL_EN
    logic [31:0] mul_res;
    assign mul_res = acc_q * word_q;
    assign acc_upd = (opcode_q == OP_MUL) ? mul_res : acc_q + word_q;
`else
    assign acc_upd = acc_q + word_q;
`endif

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        push_en   = 1'b0;
        push_data = skid_q;
        if (skid_valid_q) begin
            push_en = !fifo_full;
        end else if (byte_fire && state_q == PAYLOAD && opcode_q == OP_ECHO) begin
            push_en   = !fifo_full;
            push_data = rx_data;
        end else if (result_push) begin
            push_en   = 1'b1;
            push_data = acc_q[{res_idx_q, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            opcode_q     <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            word_q       <= '0;
            word_done_q  <= 1'b0;
            acc_q        <= '0;
            have_word_q  <= 1'b0;
            res_idx_q    <= '0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            word_done_q <= 1'b0;
            if (skid_valid_q && !fifo_full) skid_valid_q <= 1'b0;
            if (word_done_q) begin
                have_word_q <= 1'b1;
                acc_q       <= have_word_q ? acc_upd : word_q;
            end
            case (state_q)
                IDLE: begin
                    if (byte_fire && op_supported(rx_data)) begin
                        opcode_q    <= rx_data;
                        cnt_q       <= 16'd1;
                        acc_q       <= '0;
                        have_word_q <= 1'b0;
                        state_q     <= HDR;
                    end
                end
                HDR: begin
                    if (byte_fire) begin
                        cnt_q <= cnt_q + 16'd1;
                        if (cnt_q == 16'd2) len_q[7:0] <= rx_data;
                        if (cnt_q == 16'd3) begin
                            len_q[15:8] <= rx_data;
                            res_idx_q   <= '0;
                            if ({rx_data, len_q[7:0]} > 16'd4) state_q <= PAYLOAD;
                            else if (opcode_q == OP_ECHO)      state_q <= IDLE;
                            else                               state_q <= RESULT;
                        end
                    end
                end
                PAYLOAD: begin
                    if (byte_fire) begin
                        cnt_q <= cnt_q + 16'd1;
                        if (opcode_q == OP_ECHO) begin
                            if (fifo_full) begin
                                skid_q       <= rx_data;
                                skid_valid_q <= 1'b1;
                            end
                        end else begin
                            word_q <= {rx_data, word_q[31:8]};
                            // Payload starts at byte 4, so index bits [1:0]==3 end a word.
                            if (cnt_q[1:0] == 2'd3) word_done_q <= 1'b1;
                        end
                        if (cnt_q == len_q - 16'd1) begin
                            res_idx_q <= '0;
                            state_q   <= (opcode_q == OP_ECHO) ? IDLE : RESULT;
                        end
                    end
                end
                RESULT: begin
                    if (result_push) begin
                        res_idx_q <= res_idx_q + 2'd1;
                        if (res_idx_q == 2'd3) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu.sv
// Directed self-checking bench for uart_alu: drives 8N1 frames on rx_i and decodes tx_o.
// Compile with +define+UART_ALU_MUL_EN to exercise the multiply path.
module tb_uart_alu;

    localparam logic [15:0] PRESCALE = 16'd4;
    localparam int          BIT      = 32;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx_i = 1'b1;
    logic tx_o;

    int   vectors = 0;
    int   miscompares = 0;
    bq_t  rx_q;
    bq_t  pkt;
    bq_t  exp;
    logic low_seen;

    always #5 clk = ~clk;

    uart_alu #(.PRESCALE(PRESCALE)) dut (
        .clk  (clk),
        .rst  (rst),
        .rx_i (rx_i),
        .tx_o (tx_o)
    );

    // Serial monitor: samples each bit in its middle, queues decoded bytes.
    initial begin : monitor
        logic [7:0] mon_b;
        forever begin
            @(negedge clk);
            if (tx_o === 1'b0) begin
                repeat (BIT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    mon_b[i] = tx_o;
                end
                repeat (BIT) @(negedge clk);
                rx_q.push_back(mon_b);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx_i = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx_i = stop_bit;
        repeat (BIT) @(negedge clk);
        rx_i = 1'b1;
    endtask

    task automatic send_pkt(input bq_t bs);
        foreach (bs[i]) send_byte(bs[i], 1'b1);
    endtask

    // Waits (bounded) for the expected bytes, compares them, then checks the line stays quiet.
    task automatic expect_bytes(input string tag, input bq_t want);
        int waited;
        logic [31:0] got;
        waited = 0;
        while (rx_q.size() < want.size() && waited < (want.size() + 2) * 12 * BIT) begin
            @(negedge clk);
            waited++;
        end
        foreach (want[i]) begin
            got = (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD_BEEF;
            check($sformatf("%s byte%0d", tag, i), got, {24'h0, want[i]});
        end
        repeat (12 * BIT) @(negedge clk);
        check($sformatf("%s count", tag), rx_q.size(), want.size());
        rx_q.delete();
    endtask

    initial begin
        // Reset: held low for 5 cycles, then 10 quiet bit times.
        repeat (5) @(negedge clk);
        check("reset tx_o", {31'h0, tx_o}, 32'h1);
        rst = 1'b1;
        low_seen = 1'b0;
        repeat (10 * BIT) begin
            @(negedge clk);
            if (tx_o !== 1'b1) low_seen = 1'b1;
        end
        check("idle after reset", {31'h0, low_seen}, 32'h0);

        pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        send_pkt(pkt);
        exp = '{8'h41, 8'h42, 8'h43};
        expect_bytes("echo", exp);

        pkt = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'h02, 8'h00, 8'h00, 8'h00};
        send_pkt(pkt);
        exp = '{8'h01, 8'h00, 8'h00, 8'h00};
        expect_bytes("add wrap", exp);

        pkt = '{8'h11, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
                8'h05, 8'h00, 8'h00, 8'h00};
        send_pkt(pkt);
`ifdef UART_ALU_MUL_EN
        exp = '{8'h0F, 8'h00, 8'h00, 8'h00};
`else
        exp = '{};
`endif
        expect_bytes("mul", exp);

        pkt = '{8'h55, 8'h10, 8'h00, 8'h04, 8'h00};
        send_pkt(pkt);
        exp = '{8'h00, 8'h00, 8'h00, 8'h00};
        expect_bytes("bad op + empty add", exp);

        // An opcode byte with a low stop bit must not open a packet.
        send_byte(8'h10, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        exp = '{};
        expect_bytes("frame error", exp);
        pkt = '{8'h10, 8'h00, 8'h08, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        send_pkt(pkt);
        exp = '{8'h07, 8'h00, 8'h00, 8'h00};
        expect_bytes("add after frame error", exp);

        // Trailing partial word is ignored.
        pkt = '{8'h10, 8'h00, 8'h09, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h77};
        send_pkt(pkt);
        exp = '{8'h05, 8'h00, 8'h00, 8'h00};
        expect_bytes("add trailing", exp);

        // Reset in the middle of an echo payload.
        pkt = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h41};
        send_pkt(pkt);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("mid reset tx_o", {31'h0, tx_o}, 32'h1);
        rst = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        rx_q.delete();
        pkt = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h34, 8'h12, 8'h00, 8'h00,
                8'h01, 8'h01, 8'h00, 8'h00};
        send_pkt(pkt);
        exp = '{8'h35, 8'h13, 8'h00, 8'h00};
        expect_bytes("add after reset", exp);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
